// File: rtl/pipeline_pkg.sv
// Shared encodings for the EX stage: ALU function codes, multiply/divide op codes
// and the iteration count of the multiply/divide unit.
package pipeline_pkg;

    localparam int MD_CYCLES = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_fun_e;

    // Nine operations share eight codes: MTHI and MTLO use MD_MT, and
    // Ex_ALUFun[0] selects the target register (0 = HI, 1 = LO).
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_MT    = 3'd7
    } md_op_e;

    function automatic logic md_is_long(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/pipeline_ex_md_unit.sv
// Iterative 32-step multiply (shift-add) and, with PIPELINE_EX_DIV_EN, restoring divide.
// hi/lo carry the final signed-corrected result during the cycle that done is high.
module md_unit
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);
    localparam int CW = $clog2(MD_CYCLES);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_acc;
    logic [31:0]   r_opnd;
    logic          r_neg_lo;

    logic          w_signed;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic [32:0]   w_msum;
    logic [63:0]   w_mstep;
    logic [63:0]   w_step;
    logic [63:0]   w_prod;

    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_a_neg  = w_signed && a[31];
    assign w_b_neg  = w_signed && b[31];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Multiply step: conditionally add multiplicand to the upper half, then shift right.
    assign w_msum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mstep = {w_msum, r_acc[31:1]};

`ifdef PIPELINE_EX_DIV_EN
    logic          r_is_div;
    logic          r_neg_hi;
    logic          r_dz;
    logic [31:0]   r_dvd;
    logic [32:0]   w_rsh;
    logic [32:0]   w_diff;
    logic [63:0]   w_dstep;
    logic          w_start_div;

    // Divide step: acc = {remainder, dividend/quotient}; shift one dividend bit in.
    assign w_rsh       = {r_acc[63:32], r_acc[31]};
    assign w_diff      = w_rsh - {1'b0, r_opnd};
    assign w_dstep     = (w_rsh >= {1'b0, r_opnd}) ? {w_diff[31:0], r_acc[30:0], 1'b1}
                                                   : {w_rsh[31:0], r_acc[30:0], 1'b0};
    assign w_step      = r_is_div ? w_dstep : w_mstep;
    assign w_start_div = (op == MD_DIV) || (op == MD_DIVU);
`else
    assign w_step = w_mstep;
`endif

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CW'(MD_CYCLES - 1));

    always_comb begin
        w_prod = r_neg_lo ? -w_step : w_step;
        hi     = w_prod[63:32];
        lo     = w_prod[31:0];
`ifdef PIPELINE_EX_DIV_EN
        if (r_is_div) begin
            if (r_dz) begin
                lo = 32'hFFFF_FFFF;
                hi = r_dvd;
            end else begin
                lo = r_neg_lo ? -w_step[31:0]  : w_step[31:0];
                hi = r_neg_hi ? -w_step[63:32] : w_step[63:32];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_busy <= !done;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start && !r_busy) begin
            r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef PIPELINE_EX_DIV_EN
            r_is_div <= w_start_div;
            r_neg_hi <= w_a_neg;
            r_dz     <= (b == 32'd0);
            r_dvd    <= a;
            r_opnd   <= w_start_div ? w_b_mag : w_a_mag;
            r_acc    <= {32'd0, (w_start_div ? w_a_mag : w_b_mag)};
`else
            r_opnd   <= w_a_mag;
            r_acc    <= {32'd0, w_b_mag};
`endif
        end else if (r_busy) begin
            r_acc <= w_step;
        end
    end

endmodule

// File: rtl/pipeline_ex.sv
// EX stage: ALU, HI/LO registers with iterative multiply/divide, and the EX/MEM register.
// Define PIPELINE_EX_DIV_EN to build the divider; otherwise DIV/DIVU behave as no-ops.
module pipeline_ex
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Ex_BusA,
    input  logic [31:0] Ex_BusB,
    input  logic [31:0] Ex_Imm32,
    input  logic        Ex_ALUSrc2,
    input  logic [4:0]  Ex_Shamt,
    input  logic [3:0]  Ex_ALUFun,
    input  logic [2:0]  Ex_MdOp,
    input  logic        Ex_MemRd,
    input  logic        Ex_MemWr,
    input  logic        Ex_RegWr,
    input  logic [4:0]  Ex_Rd,
    input  logic        Ex_flush,
    output logic [31:0] Mem_in,
    output logic [31:0] Mem_BusB,
    output logic        Mem_MemRd,
    output logic        Mem_MemWr,
    output logic        Mem_RegWr,
    output logic [4:0]  Mem_Rd,
    output logic        Ex_stall
);
    logic [31:0]        w_b;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic [31:0]        w_alu;
    logic [31:0]        w_result;
    md_op_e             w_mdop;
    logic               w_busy;
    logic               w_done;
    logic               w_start;
    logic               w_mt;
    logic               w_bubble;
    logic [31:0]        w_md_hi;
    logic [31:0]        w_md_lo;

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_mem_in;
    logic [31:0]        r_mem_busb;
    logic               r_mem_rd;
    logic               r_mem_wr;
    logic               r_reg_wr;
    logic [4:0]         r_rd;

    assign w_b  = Ex_ALUSrc2 ? Ex_Imm32 : Ex_BusB;
    assign w_sa = $signed(Ex_BusA);
    assign w_sb = $signed(w_b);

    always_comb begin
        w_alu = '0;
        case (alu_fun_e'(Ex_ALUFun))
            ALU_ADD:  w_alu = Ex_BusA + w_b;
            ALU_SUB:  w_alu = Ex_BusA - w_b;
            ALU_AND:  w_alu = Ex_BusA & w_b;
            ALU_OR:   w_alu = Ex_BusA | w_b;
            ALU_XOR:  w_alu = Ex_BusA ^ w_b;
            ALU_NOR:  w_alu = ~(Ex_BusA | w_b);
            ALU_SLT:  w_alu = {31'd0, (w_sa < w_sb)};
            ALU_SLTU: w_alu = {31'd0, (Ex_BusA < w_b)};
            ALU_SLL:  w_alu = w_b << Ex_Shamt;
            ALU_SRL:  w_alu = w_b >> Ex_Shamt;
            ALU_SRA:  w_alu = w_sb >>> Ex_Shamt;
            ALU_LUI:  w_alu = {w_b[15:0], 16'd0};
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_mdop = md_op_e'(Ex_MdOp);
`ifndef PIPELINE_EX_DIV_EN
        if ((w_mdop == MD_DIV) || (w_mdop == MD_DIVU)) begin
            w_mdop = MD_NONE;
        end
`endif
    end

    // Flushed instructions never start or touch HI/LO; an op already running is left alone.
    assign Ex_stall = w_busy && (w_mdop != MD_NONE);
    assign w_start  = md_is_long(w_mdop) && !w_busy && !Ex_flush;
    assign w_mt     = (w_mdop == MD_MT) && !w_busy && !Ex_flush;
    assign w_bubble = Ex_flush || Ex_stall;

    always_comb begin
        w_result = w_alu;
        if (w_mdop == MD_MFHI) w_result = r_hi;
        if (w_mdop == MD_MFLO) w_result = r_lo;
    end

    md_unit u_md (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .op    (w_mdop),
        .a     (Ex_BusA),
        .b     (w_b),
        .busy  (w_busy),
        .hi    (w_md_hi),
        .lo    (w_md_lo),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_md_hi;
            r_lo <= w_md_lo;
        end else if (w_mt) begin
            if (Ex_ALUFun[0]) r_lo <= Ex_BusA;
            else              r_hi <= Ex_BusA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_in   <= '0;
            r_mem_busb <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_rd       <= '0;
        end else if (w_bubble) begin
            r_mem_in   <= '0;
            r_mem_busb <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_rd       <= '0;
        end else begin
            r_mem_in   <= w_result;
            r_mem_busb <= Ex_BusB;
            r_mem_rd   <= Ex_MemRd;
            r_mem_wr   <= Ex_MemWr;
            r_reg_wr   <= Ex_RegWr;
            r_rd       <= Ex_Rd;
        end
    end

    assign Mem_in    = r_mem_in;
    assign Mem_BusB  = r_mem_busb;
    assign Mem_MemRd = r_mem_rd;
    assign Mem_MemWr = r_mem_wr;
    assign Mem_RegWr = r_reg_wr;
    assign Mem_Rd    = r_rd;

endmodule

// File: tb/tb_pipeline_ex.sv
// Directed and randomized bench for pipeline_ex against an arithmetic reference model
// (64-bit products, native divide/modulo, explicit HI/LO state).
module tb_pipeline_ex;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Ex_BusA, Ex_BusB, Ex_Imm32;
    logic        Ex_ALUSrc2;
    logic [4:0]  Ex_Shamt;
    logic [3:0]  Ex_ALUFun;
    logic [2:0]  Ex_MdOp;
    logic        Ex_MemRd, Ex_MemWr, Ex_RegWr;
    logic [4:0]  Ex_Rd;
    logic        Ex_flush;
    logic [31:0] Mem_in, Mem_BusB;
    logic        Mem_MemRd, Mem_MemWr, Mem_RegWr;
    logic [4:0]  Mem_Rd;
    logic        Ex_stall;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

`ifdef PIPELINE_EX_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    pipeline_ex dut (
        .clk        (clk),
        .reset      (reset),
        .Ex_BusA    (Ex_BusA),
        .Ex_BusB    (Ex_BusB),
        .Ex_Imm32   (Ex_Imm32),
        .Ex_ALUSrc2 (Ex_ALUSrc2),
        .Ex_Shamt   (Ex_Shamt),
        .Ex_ALUFun  (Ex_ALUFun),
        .Ex_MdOp    (Ex_MdOp),
        .Ex_MemRd   (Ex_MemRd),
        .Ex_MemWr   (Ex_MemWr),
        .Ex_RegWr   (Ex_RegWr),
        .Ex_Rd      (Ex_Rd),
        .Ex_flush   (Ex_flush),
        .Mem_in     (Mem_in),
        .Mem_BusB   (Mem_BusB),
        .Mem_MemRd  (Mem_MemRd),
        .Mem_MemWr  (Mem_MemWr),
        .Mem_RegWr  (Mem_RegWr),
        .Mem_Rd     (Mem_Rd),
        .Ex_stall   (Ex_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {24'd0, Mem_MemRd, Mem_MemWr, Mem_RegWr, Mem_Rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Ex_BusA = '0; Ex_BusB = '0; Ex_Imm32 = '0; Ex_ALUSrc2 = 1'b0;
        Ex_Shamt = '0; Ex_ALUFun = '0; Ex_MdOp = MD_NONE;
        Ex_MemRd = 1'b0; Ex_MemWr = 1'b0; Ex_RegWr = 1'b0; Ex_Rd = '0; Ex_flush = 1'b0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] fun, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        int sa, sb;
        longint q;
        sa = int'(a);
        sb = int'(b);
        case (fun)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b * (32'd1 << sh);
            4'd9:  return b / (32'd1 << sh);
            4'd10: begin
                // arithmetic shift = floor division by 2^sh
                q = longint'(sb) - ((sb < 0) ? ((longint'(1) << sh) - 1) : 0);
                q = q / (longint'(1) << sh);
                return q[31:0];
            end
            4'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit op_runs(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (DIV_ON && ((op == MD_DIV) || (op == MD_DIVU)));
    endfunction

    task automatic model_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sp, q, r;
        longint unsigned up;
        if (op == MD_MULT) begin
            sp = longint'(int'(a)) * longint'(int'(b));
            m_hi = sp[63:32]; m_lo = sp[31:0];
        end else if (op == MD_MULTU) begin
            up = longint'({32'd0, a}) * longint'({32'd0, b});
            m_hi = up[63:32]; m_lo = up[31:0];
        end else if (op_runs(op)) begin
            if (b == 32'd0) begin
                m_lo = 32'hFFFF_FFFF; m_hi = a;
            end else if (op == MD_DIV) begin
                q = longint'(int'(a)) / longint'(int'(b));
                r = longint'(int'(a)) % longint'(int'(b));
                m_lo = q[31:0]; m_hi = r[31:0];
            end else begin
                m_lo = a / b; m_hi = a % b;
            end
        end
    endtask

    task automatic count_stall(input int limit, output int n, output int bad);
        n = 0; bad = 0;
        #1;
        while ((Ex_stall === 1'b1) && (n < limit)) begin
            tick();
            n++;
            if ((Mem_MemRd | Mem_MemWr | Mem_RegWr) !== 1'b0) bad++;
        end
    endtask

    task automatic read_hilo(input string tag, input int exp_lat);
        int n, bad;
        idle(); Ex_MdOp = MD_MFLO; Ex_RegWr = 1'b1; Ex_Rd = 5'd9;
        count_stall(40, n, bad);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_bubble"}, bad, 0);
        tick();
        check({tag, "_lo"}, Mem_in, m_lo);
        check({tag, "_lo_ctl"}, ctl(), {24'd0, 3'b001, 5'd9});
        idle(); Ex_MdOp = MD_MFHI; Ex_RegWr = 1'b1; Ex_Rd = 5'd10;
        tick();
        check({tag, "_hi"}, Mem_in, m_hi);
    endtask

    task automatic run_md(input string tag, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        idle(); Ex_MdOp = op; Ex_BusA = a; Ex_BusB = b;
        tick();
        model_md(op, a, b);
        read_hilo(tag, op_runs(op) ? 32 : 0);
    endtask

    initial begin
        logic [31:0] a, b, exp_v;
        int n, bad;
        md_op_e rop;

        idle();
        reset = 1'b0;
        #3;
        check("reset_mem_in", Mem_in, 32'd0);
        check("reset_ctl", ctl(), 32'd0);
        check("reset_stall", {31'd0, Ex_stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        idle(); Ex_BusA = 32'h7FFF_FFFF; Ex_BusB = 32'd1; Ex_ALUFun = ALU_ADD; Ex_RegWr = 1'b1; Ex_Rd = 5'd3;
        tick();
        check("add_overflow_wrap", Mem_in, 32'h8000_0000);
        check("add_ctl", ctl(), {24'd0, 3'b001, 5'd3});

        idle(); Ex_BusA = 32'hFFFF_FFFF; Ex_BusB = 32'd1; Ex_ALUFun = ALU_SLT;
        tick();
        check("slt_neg1_1", Mem_in, 32'd1);
        Ex_ALUFun = ALU_SLTU;
        tick();
        check("sltu_neg1_1", Mem_in, 32'd0);

        for (int i = 0; i < 30; i++) begin
            idle();
            Ex_BusA = $urandom; Ex_BusB = $urandom; Ex_Imm32 = $urandom;
            Ex_ALUSrc2 = 1'($urandom_range(0, 1)); Ex_Shamt = 5'($urandom);
            Ex_ALUFun = 4'($urandom_range(0, 11));
            Ex_MemRd = 1'($urandom); Ex_MemWr = 1'($urandom); Ex_RegWr = 1'($urandom); Ex_Rd = 5'($urandom);
            exp_v = ref_alu(Ex_ALUFun, Ex_BusA, Ex_ALUSrc2 ? Ex_Imm32 : Ex_BusB, Ex_Shamt);
            a = {24'd0, Ex_MemRd, Ex_MemWr, Ex_RegWr, Ex_Rd};
            b = Ex_BusB;
            tick();
            check($sformatf("alu_rand_f%0d", Ex_ALUFun), Mem_in, exp_v);
            check("alu_rand_busb", Mem_BusB, b);
            check("alu_rand_ctl", ctl(), a);
        end

        run_md("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_m3x5_lo_const", m_lo, 32'hFFFF_FFF1);
        run_md("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_7d0", MD_DIVU, 32'd7, 32'd0);
        run_md("div_m9d0", MD_DIV, 32'hFFFF_FFF7, 32'd0);

        for (int i = 0; i < 6; i++) begin
            rop = md_op_e'($urandom_range(1, 4));
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            run_md($sformatf("md_rand%0d_op%0d", i, rop), rop, a, b);
        end

        idle(); Ex_MdOp = MD_MT; Ex_ALUFun = 4'd0; Ex_BusA = 32'h1234_5678;
        tick();
        Ex_ALUFun = 4'd1; Ex_BusA = 32'h9ABC_DEF0;
        tick();
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
        read_hilo("mthi_mtlo", 0);

        a = 32'h0001_2345; b = 32'hFFFF_F00D;
        idle(); Ex_MdOp = MD_MULT; Ex_BusA = a; Ex_BusB = b;
        tick();
        model_md(MD_MULT, a, b);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            idle(); Ex_ALUFun = ALU_ADD; Ex_BusA = $urandom; Ex_BusB = $urandom; Ex_RegWr = 1'b1; Ex_Rd = 5'(i + 1);
            exp_v = Ex_BusA + Ex_BusB;
            #1;
            if (Ex_stall !== 1'b0) bad++;
            tick();
            check($sformatf("add_during_busy%0d", i), Mem_in, exp_v);
            check($sformatf("add_during_busy_ctl%0d", i), ctl(), {24'd0, 3'b001, 5'(i + 1)});
        end
        check("add_during_busy_nostall", bad, 0);
        read_hilo("mult_then_adds", 27);

        idle(); Ex_ALUFun = ALU_ADD; Ex_BusA = 32'd5; Ex_RegWr = 1'b1; Ex_MemWr = 1'b1; Ex_Rd = 5'd4; Ex_flush = 1'b1;
        tick();
        check("flush_idle_bubble", ctl(), 32'd0);
        idle(); Ex_MdOp = MD_MULT; Ex_BusA = 32'd7; Ex_BusB = 32'd7; Ex_flush = 1'b1;
        tick();
        read_hilo("flush_no_issue", 0);

        a = 32'hFFFF_FF00; b = 32'h0000_0101;
        idle(); Ex_MdOp = MD_MULT; Ex_BusA = a; Ex_BusB = b;
        tick();
        model_md(MD_MULT, a, b);
        idle(); Ex_MdOp = MD_MULTU; Ex_BusA = 32'd3; Ex_BusB = 32'd3;
        Ex_flush = 1'b1; Ex_RegWr = 1'b1; Ex_MemRd = 1'b1; Ex_Rd = 5'd7;
        #1;
        check("flush_stall_active", {31'd0, Ex_stall}, 32'd1);
        tick();
        check("flush_stall_bubble", ctl(), 32'd0);
        read_hilo("flush_during_busy", 31);

        idle(); Ex_MdOp = MD_MULT; Ex_BusA = 32'd1000; Ex_BusB = 32'd1000;
        tick();
        for (int i = 0; i < 9; i++) begin
            idle(); Ex_ALUFun = ALU_OR; Ex_BusA = 32'h0F00_0000; Ex_BusB = 32'd100 + i;
            Ex_RegWr = 1'b1; Ex_Rd = 5'd12;
            tick();
        end
        check("pre_reset_mem_in", Mem_in, 32'h0F00_0000 | 32'd108);
        idle(); Ex_MdOp = MD_MFLO; Ex_RegWr = 1'b1; Ex_Rd = 5'd13;
        #1;
        check("pre_reset_stall", {31'd0, Ex_stall}, 32'd1);
        reset = 1'b0;
        #1;
        check("midop_reset_mem_in", Mem_in, 32'd0);
        check("midop_reset_busb", Mem_BusB, 32'd0);
        check("midop_reset_ctl", ctl(), 32'd0);
        check("midop_reset_stall", {31'd0, Ex_stall}, 32'd0);
        #1 reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        idle();
        repeat (30) tick();
        read_hilo("after_reset_abandon", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_ex.md
PIPELINE_EX -- requirements
Module: pipeline_ex

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs Ex_BusA, Ex_BusB, Ex_Imm32  input  32 each  operands from ID/EX.
REQ-004 SHALL have inputs Ex_ALUSrc2  input  1  (1 = Imm32 as B); Ex_Shamt  input  5  shift amount; Ex_ALUFun  input  4  ALU op code.
REQ-005 SHALL have inputs Ex_MdOp  input  3  multiply/divide op code; Ex_MemRd, Ex_MemWr, Ex_RegWr  input  1 each; Ex_Rd  input  5  destination register.
REQ-006 SHALL have input Ex_flush  input  1  load bubble into EX/MEM.
REQ-007 SHALL have outputs Mem_in  output  32  registered result/address; Mem_BusB  output  32  registered store data.
REQ-008 SHALL have outputs Mem_MemRd, Mem_MemWr, Mem_RegWr  output  1 each; Mem_Rd  output  5.
REQ-009 SHALL have output Ex_stall  output  1  combinational; holds PC, IF/ID and ID/EX.

Function
REQ-010 SHALL compute, with B = Ex_ALUSrc2 ? Ex_Imm32 : Ex_BusB: ADD, SUB (32-bit wrap, no overflow trap), AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (by Ex_Shamt), LUI (B<<16).
REQ-011 SHALL register result, Ex_BusB, MemRd/MemWr/RegWr/Rd into EX/MEM each edge; latency exactly 1 cycle.
REQ-012 SHALL contain 32-bit HI and LO registers, both 0 after reset.
REQ-013 SHALL decode Ex_MdOp: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-014 SHALL start MULT/MULTU/DIV/DIVU at the edge ending issue cycle T when not busy; busy high T+1..T+32; HI/LO written at edge ending T+32.
REQ-015 SHALL implement multiply as 32-step shift-add on magnitudes; product negated when signed and operand signs differ; HI=upper, LO=lower 64-bit half.
REQ-016 SHALL implement divide as 32-step restoring division on magnitudes; LO=quotient (sign = signA^signB), HI=remainder (sign = dividend) for DIV.
REQ-017 SHALL on divisor 0 set LO=0xFFFFFFFF, HI=dividend, with unchanged 32-cycle latency.
REQ-018 SHALL assert Ex_stall while busy and Ex_MdOp is any op other than NONE; the EX/MEM register loads a bubble (MemRd=MemWr=RegWr=0) during stall.
REQ-019 SHALL deassert Ex_stall in T+33; MFHI/MFLO then output the new HI/LO as result.
REQ-020 SHALL execute MTHI/MTLO in one cycle (HI or LO <= Ex_BusA), only when not busy.
REQ-021 SHALL on Ex_flush load a bubble into EX/MEM and not issue Ex_MdOp; an in-flight multiply/divide is not aborted.
REQ-022 SHALL give Ex_flush priority over Ex_stall for the EX/MEM content.
REQ-023 SHALL treat ALU/memory ops arriving while busy (Ex_MdOp=NONE) as non-stalling.

Reset
REQ-024 SHALL on reset low clear EX/MEM outputs to 0, HI=LO=0, busy=0, counter=0, Ex_stall=0, immediately regardless of clk.
REQ-025 SHALL abandon any in-flight multiply/divide on reset; no HI/LO update afterward.

Configuration
REQ-026 SHALL compile the divider only with PIPELINE_EX_DIV_EN defined.
REQ-027 SHALL without PIPELINE_EX_DIV_EN treat DIV/DIVU as NONE: no busy, HI/LO unchanged, no stall.

Structure
REQ-028 SHALL place ALUFun and MdOp encodings and MD_CYCLES=32 in shared package pipeline_pkg.
REQ-029 SHALL implement the iterative multiply/divide datapath and counter as sub-module md_unit (start, op, a, b -> busy, hi, lo, done).

Verification
REQ-030 SHALL cover: ADD 0x7FFFFFFF+1 -> Mem_in=0x80000000 one cycle later; SLT -1,1 -> 1; SLTU -1,1 -> 0.
REQ-031 SHALL cover: MULT -3 x 5 then MFLO next -> stall 32 cycles, LO=0xFFFFFFF1, HI=0xFFFFFFFF.
REQ-032 SHALL cover: DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 SHALL cover: MULT followed by 5 ADDs -> no stall, ADD results correct, HI/LO valid at T+33.
REQ-034 SHALL cover: reset low at busy cycle 10 -> HI=LO=0, Ex_stall=0, EX/MEM zero immediately.
REQ-035 SHALL cover: Ex_flush with stall active -> EX/MEM bubble, multiply completes normally.
